fixed_cos_cordic: RTL and testbench

//  Iterative CORDIC (rotation mode) cosine unit in the fixed-point domain.

---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_cos_step.sv | 37 +++
 rtl/fixed_cos_cordic.sv | 150 +++++++++++++++
 tb/tb_fixed_cos_cordic.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, widths, tables and FSM states for the fixed-point CORDIC cosine unit.
package cordic_pkg;

  localparam int FRAC_W_DEF = 19;
  localparam int GUARD_DEF  = 3;
  localparam int ITER_DEF   = 20;

  // Iteration counter width; large enough to index the full 32-entry arctangent table.
  localparam int CNT_W = 5;

  // CORDIC gain compensation 0.6072529350 at 32 fractional bits.
  localparam logic [31:0] K_Q32 = 32'd2608131496;

  // atan(2^-i) for i = 0..31 at 32 fractional bits.
  localparam logic [31:0] ATAN_Q32 [0:31] = '{
    32'd3373259426, 32'd1991351318, 32'd1052175346, 32'd534100635,
    32'd268086748,  32'd134174063,  32'd67103403,   32'd33553749,
    32'd16777131,   32'd8388597,    32'd4194303,    32'd2097152,
    32'd1048576,    32'd524288,     32'd262144,     32'd131072,
    32'd65536,      32'd32768,      32'd16384,      32'd8192,
    32'd4096,       32'd2048,       32'd1024,       32'd512,
    32'd256,        32'd128,        32'd64,         32'd32,
    32'd16,         32'd8,          32'd4,          32'd2
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ROUND,
    S_DONE
  } state_t;

  // Internal datapath width: sign, two integer bits, fraction plus guard bits.
  function automatic int cordic_w(input int frac_w, input int guard);
    return 3 + frac_w + guard;
  endfunction

  // Re-scale a 32-fractional-bit constant to fb fractional bits, rounding to nearest.
  function automatic logic [63:0] slice_q32(input logic [31:0] v, input int fb);
    logic [63:0] t;
    t = {32'd0, v};
    if (fb >= 32) begin
      return t << (fb - 32);
    end
    return (t + (64'd1 << (31 - fb))) >> (32 - fb);
  endfunction

endpackage

// File: rtl/cordic_cos_step.sv
// One combinational rotation-mode CORDIC micro-rotation driven by the sign of the residual angle.
module cordic_cos_step
  import cordic_pkg::*;
#(
  parameter int W  = 25,
  parameter int FB = 22
) (
  input  logic signed [W-1:0]     x,
  input  logic signed [W-1:0]     y,
  input  logic signed [W-1:0]     z,
  input  logic        [CNT_W-1:0] i,
  output logic signed [W-1:0]     x_n,
  output logic signed [W-1:0]     y_n,
  output logic signed [W-1:0]     z_n
);

  logic signed [W-1:0] atan_v;
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // Rotate towards zero residual angle; all updates use the current x, y, z.
  always_comb begin
    atan_v = W'(slice_q32(ATAN_Q32[i], FB));
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    if (!z[W-1]) begin
      x_n = x - y_sh;
      y_n = y + x_sh;
      z_n = z - atan_v;
    end else begin
      x_n = x + y_sh;
      y_n = y - x_sh;
      z_n = z + atan_v;
    end
  end

endmodule

// File: rtl/fixed_cos_cordic.sv
// Iterative CORDIC cosine on sign-magnitude fixed-point angles with valid/ready handshakes.
module fixed_cos_cordic
  import cordic_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ITER   = ITER_DEF,
  parameter int GUARD  = GUARD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_i,
  input  logic              integer_i,
  input  logic [FRAC_W-1:0] fractional_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_o,
  output logic              integer_o,
  output logic [FRAC_W-1:0] fractional_o,
  output logic              range_err_o
);

  localparam int FB = FRAC_W + GUARD;
  localparam int W  = cordic_w(FRAC_W, GUARD);
  localparam int RW = W + 1 - GUARD;

  localparam logic signed [W-1:0] K_FIX     = W'(slice_q32(K_Q32, FB));
  localparam logic [FRAC_W-1:0]   FRAC_HALF = FRAC_W'(1) << (FRAC_W - 1);
  localparam logic [W:0]          HALF_LSB  = (W+1)'(1) << (GUARD - 1);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]    cnt;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic signed [W-1:0] z_q;
  logic signed [W-1:0] x_n;
  logic signed [W-1:0] y_n;
  logic signed [W-1:0] z_n;
  logic                range_pend;
  logic                accept;
  logic                last_iter;

  logic signed [W:0]    x_ext;
  logic signed [RW-1:0] x_rnd;
  logic [RW-1:0]        mag;
  logic                 neg;
  logic                 sat;

  // cos is even, so the angle sign never affects the result.
  logic sign_unused;
  assign sign_unused = sign_i;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  cordic_cos_step #(
    .W (W),
    .FB(FB)
  ) u_step (
    .x  (x_q),
    .y  (y_q),
    .z  (z_q),
    .i  (cnt),
    .x_n(x_n),
    .y_n(y_n),
    .z_n(z_n)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept, iterate, round, then wait for the consumer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (last_iter) state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Round x to the output precision and convert to sign-magnitude with saturation at 2.0.
  always_comb begin
    x_ext = {x_q[W-1], x_q} + HALF_LSB;
    x_rnd = RW'(x_ext >>> GUARD);
    neg   = x_rnd[RW-1];
    mag   = neg ? RW'(-x_rnd) : RW'(x_rnd);
    sat   = |mag[RW-1:FRAC_W+1];
  end

  // Datapath: capture the angle, run the micro-rotations, register the rounded result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      range_pend   <= 1'b0;
      sign_o       <= 1'b0;
      integer_o    <= 1'b0;
      fractional_o <= '0;
      range_err_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            x_q        <= K_FIX;
            y_q        <= '0;
            z_q        <= {2'b00, integer_i, fractional_i, {GUARD{1'b0}}};
            cnt        <= '0;
            range_pend <= integer_i && (fractional_i > FRAC_HALF);
          end
        end
        S_RUN: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          cnt <= cnt + CNT_W'(1);
        end
        S_ROUND: begin
          sign_o      <= neg;
          range_err_o <= range_pend;
          if (sat) begin
            integer_o    <= 1'b1;
            fractional_o <= '1;
          end else begin
            integer_o    <= mag[FRAC_W];
            fractional_o <= mag[FRAC_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_cos_cordic.sv
// Scoreboard bench for the CORDIC cosine unit: expected values come from $cos.
module tb_fixed_cos_cordic;

  localparam int FRAC_W = 19;
  localparam int ITER   = 20;
  localparam int TOL    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              sign_i = 1'b0;
  logic              integer_i = 1'b0;
  logic [FRAC_W-1:0] fractional_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              sign_o;
  logic              integer_o;
  logic [FRAC_W-1:0] fractional_o;
  logic              range_err_o;

  typedef struct {
    int   exp_mag;
    logic exp_err;
    bit   check_val;
    int   accept_edge;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  edges = 0;

  fixed_cos_cordic dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_i      (sign_i),
    .integer_i   (integer_i),
    .fractional_i(fractional_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sign_o      (sign_o),
    .integer_o   (integer_o),
    .fractional_o(fractional_o),
    .range_err_o (range_err_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurement.
  always @(posedge clk) edges <= edges + 1;

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected, input int tol);
    int diff;
    vectors++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, actual, expected, tol);
    end
  endtask

  // Drive one angle, wait for it to be accepted, push the model result.
  task automatic applyStimulus(input logic s, input logic ib, input logic [FRAC_W-1:0] f, input bit check_val);
    sb_t  e;
    real  ang;
    int   waited;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1, 0);
      return;
    end
    sign_i       = s;
    integer_i    = ib;
    fractional_i = f;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    ang          = real'(ib) + real'(f) / 524288.0;
    e.exp_mag    = $rtoi($cos(ang) * 524288.0 + 0.5);
    e.exp_err    = ib && (f > 19'h40000);
    e.check_val  = check_val;
    e.accept_edge = edges;
    sb.push_back(e);
  endtask

  // Wait for the result, compare against the scoreboard head, optionally stall the consumer.
  task automatic collectResult(input string tag, input int hold);
    sb_t  e;
    int   waited;
    logic [FRAC_W-1:0] f_snap;
    logic i_snap;
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid || sb.size() == 0) begin
      checkOutput({tag, "_timeout"}, 0, 1, 0);
      if (sb.size() > 0) sb.delete(0);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, "_latency"}, edges - e.accept_edge, ITER + 1, 0);
    checkOutput({tag, "_range_err"}, int'(range_err_o), int'(e.exp_err), 0);
    checkOutput({tag, "_in_ready_busy"}, int'(in_ready), 0, 0);
    if (e.check_val) begin
      checkOutput({tag, "_sign"}, int'(sign_o), 0, 0);
      checkOutput({tag, "_mag"}, int'({integer_o, fractional_o}), e.exp_mag, TOL);
    end
    f_snap = fractional_o;
    i_snap = integer_o;
    for (int c = 0; c < hold; c++) begin
      sign_i       = 1'b0;
      integer_i    = 1'b0;
      fractional_i = 19'h12345;
      in_valid     = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, int'(out_valid), 1, 0);
      checkOutput({tag, "_hold_ready"}, int'(in_ready), 0, 0);
      checkOutput({tag, "_hold_data"}, int'({integer_o, fractional_o}), int'({i_snap, f_snap}), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, int'(out_valid), 0, 0);
    checkOutput({tag, "_idle_ready"}, int'(in_ready), 1, 0);
    checkOutput({tag, "_idle_data"}, int'({integer_o, fractional_o}), int'({i_snap, f_snap}), 0);
  endtask

  initial begin
    int v;
    logic [19:0] a;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_in_ready", int'(in_ready), 1, 0);
    checkOutput("rst_out_valid", int'(out_valid), 0, 0);
    checkOutput("rst_sign", int'(sign_o), 0, 0);
    checkOutput("rst_int", int'(integer_o), 0, 0);
    checkOutput("rst_frac", int'(fractional_o), 0, 0);
    checkOutput("rst_err", int'(range_err_o), 0, 0);

    $display("[TB] directed angles");
    applyStimulus(1'b0, 1'b0, 19'h00000, 1'b1); collectResult("zero", 0);
    applyStimulus(1'b0, 1'b1, 19'h00000, 1'b1); collectResult("one", 0);
    applyStimulus(1'b1, 1'b0, 19'h40000, 1'b1); collectResult("neg_half", 0);
    applyStimulus(1'b0, 1'b0, 19'h40000, 1'b1); collectResult("pos_half", 0);
    applyStimulus(1'b0, 1'b1, 19'h40000, 1'b1); collectResult("edge_1p5", 0);
    applyStimulus(1'b1, 1'b1, 19'h40001, 1'b1); collectResult("above_1p5", 0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 1'b0, 19'h30000, 1'b1); collectResult("stall", 10);

    $display("[TB] reset during iteration");
    applyStimulus(1'b0, 1'b1, 19'h00000, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    checkOutput("midrst_in_ready", int'(in_ready), 1, 0);
    checkOutput("midrst_out_valid", int'(out_valid), 0, 0);
    checkOutput("midrst_frac", int'(fractional_o), 0, 0);
    applyStimulus(1'b0, 1'b0, 19'h2A000, 1'b1); collectResult("after_rst", 0);

    $display("[TB] out of range angle");
    applyStimulus(1'b0, 1'b1, 19'h73333, 1'b0); collectResult("range_1p9", 0);

    $display("[TB] random angles");
    for (int n = 0; n < 8; n++) begin
      v = int'($urandom_range(786432, 0));
      a = v[19:0];
      applyStimulus(1'($urandom_range(1, 0)), a[19], a[18:0], 1'b1);
      collectResult("rand", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
